dual_input_debouncer: RTL and testbench
=======================================

Name: dual_input_debouncer

Overview:
- Upstream conditioning stage for the 2-input logic-gate lab blocks. It takes raw board switch and button levels, synchronises them to clk, debounces them and drives the clean A/B operands into the gate.
- It also emits single-cycle rise and fall pulses per channel for downstream counters and LEDs.
- Two identical, independent channels; each has its own synchroniser, stability counter and 4-state FSM.

Parameters:
- STABLE_CYCLES, 1000000, consecutive cycles a synchronised input must hold a new level before the output changes (10 ms at 100 MHz); legal range 2..2^24-1.
- CNT_W, 24, width of each stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- raw_a  in  1  raw, asynchronous switch/button level for channel A.
- raw_b  in  1  raw, asynchronous switch/button level for channel B.
- a_out  out  1  debounced level A; feeds the gate input A.
- b_out  out  1  debounced level B; feeds the gate input B.
- a_rise  out  1  one-cycle pulse when a_out goes 0->1.
- a_fall  out  1  one-cycle pulse when a_out goes 1->0.
- b_rise  out  1  one-cycle pulse when b_out goes 0->1.
- b_fall  out  1  one-cycle pulse when b_out goes 1->0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low: assertion acts immediately, regardless of clk.
- Reset values:
  - all outputs 0;
  - synchroniser flops 0;
  - counters 0;
  - FSMs in STABLE_LO.
- Synchroniser: 2 flops per channel. s = second flop. Raw-to-s latency is 2 cycles.
- FSM states and transitions (per channel):
  - STABLE_LO: out=0. If s=1, clear the counter and go to WAIT_HI.
  - WAIT_HI: out=0. If s=0, return to STABLE_LO (glitch rejected) and clear the counter. Otherwise increment the counter. When counter==STABLE_CYCLES-1 and s=1, go to STABLE_HI, set out=1 and pulse rise.
  - STABLE_HI: out=1. If s=0, clear the counter and go to WAIT_LO.
  - WAIT_LO: mirror of WAIT_HI. Bounce back to 1 returns to STABLE_HI. On completion, go to STABLE_LO, set out=0 and pulse fall.
- Latency: a clean raw edge appears on out exactly 2 + STABLE_CYCLES + 1 clk edges after the raw transition is sampled. No combinational path from raw_* to any output; all outputs are registered.
- Pulses: rise/fall are high for exactly one cycle, coincident with the first cycle of the new out level. Rise and fall of one channel are never high in the same cycle.
- Counter saturation: the counter never exceeds STABLE_CYCLES-1, so there is no wrap-around. It is cleared on every state change.
- Channel independence: simultaneous edges on raw_a and raw_b are processed independently. Both may pulse in the same cycle.
- Reset mid-operation: rst_n low during WAIT_* discards the partial count. After release, a held-high input needs a full 2+STABLE_CYCLES+1 cycles to assert out again.
- Unknown states (unreachable encodings) recover to STABLE_LO with out=0.

Test Plan:
(bench overrides STABLE_CYCLES=8)
- Reset: rst_n=0 with raw_a=raw_b=1 -> all outputs 0 asynchronously. After release, a_out=b_out=1 exactly 11 cycles later, with one-cycle a_rise and b_rise pulses in that cycle.
- Bounce rejection: raw_a toggles 1,0,1,0 every 3 cycles, then holds 0 -> a_out stays 0, a_rise never asserts.
- Clean press/release: raw_a 0->1 held 20 cycles, then ->0 -> a_out=1 at cycle 11 after the rise, a_fall pulse and a_out=0 at cycle 11 after the fall. Exactly one a_rise and one a_fall.
- Gate drive: raw_a=1, raw_b=1 held -> a_out&b_out=1 after 11 cycles. Drop raw_b -> b_out=0 after 11 cycles while a_out stays 1.
- Edge-of-window glitch: raw_b held 1 for 7 cycles then 0 for 1 cycle then 1 -> no b_rise until 8 further stable cycles have passed.
- Mid-count reset: raw_a=1, assert rst_n=0 at cycle 6, release at cycle 9 -> a_out=0 throughout. a_out=1 only 11 cycles after release.

Source files
------------

// File: rtl/dual_input_debouncer.sv
// Two-channel switch/button conditioner: synchronise, debounce, and emit
// single-cycle rise/fall pulses. Channels A and B are fully independent.
module dual_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_a,
    input  logic raw_b,
    output logic a_out,
    output logic b_out,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    // Final count value; the counter stops here, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] out_w;
    logic [1:0] rise_w;
    logic [1:0] fall_w;

    assign raw = {raw_b, raw_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             rise_q;
        logic             fall_q;

        // Two-flop synchroniser for the asynchronous raw level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= raw[ch];
                sync2_q <= sync1_q;
            end
        end

        // Debounce FSM with stability counter and registered level/pulse outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    STABLE_LO: begin
                        out_q <= 1'b0;
                        if (sync2_q) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        out_q <= 1'b0;
                        if (!sync2_q) begin
                            cnt_q   <= '0;
                            state_q <= STABLE_LO;
                        end else if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= STABLE_HI;
                            out_q   <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    STABLE_HI: begin
                        out_q <= 1'b1;
                        if (!sync2_q) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        out_q <= 1'b1;
                        if (sync2_q) begin
                            cnt_q   <= '0;
                            state_q <= STABLE_HI;
                        end else if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= STABLE_LO;
                            out_q   <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= STABLE_LO;
                        out_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign out_w[ch]  = out_q;
        assign rise_w[ch] = rise_q;
        assign fall_w[ch] = fall_q;
    end

    assign a_out  = out_w[0];
    assign b_out  = out_w[1];
    assign a_rise = rise_w[0];
    assign b_rise = rise_w[1];
    assign a_fall = fall_w[0];
    assign b_fall = fall_w[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Directed bench for dual_input_debouncer with STABLE_CYCLES=8 (11-edge latency).
module tb_dual_input_debouncer;

    logic clk;
    logic rst_n;
    logic raw_a;
    logic raw_b;
    logic a_out;
    logic b_out;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    int checks;
    int errors;

    dual_input_debouncer #(
        .STABLE_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_a (raw_a),
        .raw_b (raw_b),
        .a_out (a_out),
        .b_out (b_out),
        .a_rise(a_rise),
        .a_fall(a_fall),
        .b_rise(b_rise),
        .b_fall(b_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        raw_a = 1'b1;
        raw_b = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_out, b_out, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async outputs=%b expected=000000",
                     {a_out, b_out, a_rise, a_fall, b_rise, b_fall});
        end
        idle(3);
        checks++;
        if ({a_out, b_out, a_rise, a_fall, b_rise, b_fall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_held outputs=%b expected=000000",
                     {a_out, b_out, a_rise, a_fall, b_rise, b_fall});
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 10) begin
                checks++;
                if ({a_out, b_out, a_rise, b_rise} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_release_early got=%b expected=0000",
                             {a_out, b_out, a_rise, b_rise});
                end
            end
            if (i == 11) begin
                checks++;
                if ({a_out, b_out, a_rise, b_rise, a_fall, b_fall} !== 6'b111100) begin
                    errors++;
                    $display("FAIL reset_release_rise got=%b expected=111100",
                             {a_out, b_out, a_rise, b_rise, a_fall, b_fall});
                end
            end
            if (i == 12) begin
                checks++;
                if ({a_out, b_out, a_rise, b_rise} !== 4'b1100) begin
                    errors++;
                    $display("FAIL reset_rise_one_cycle got=%b expected=1100",
                             {a_out, b_out, a_rise, b_rise});
                end
            end
        end
        // Return both channels low; both fall pulses land in the same cycle.
        raw_a = 1'b0;
        raw_b = 1'b0;
        idle(10);
        checks++;
        if ({a_out, b_out, a_fall, b_fall} !== 4'b1100) begin
            errors++;
            $display("FAIL both_fall_early got=%b expected=1100", {a_out, b_out, a_fall, b_fall});
        end
        tick();
        checks++;
        if ({a_out, b_out, a_fall, b_fall} !== 4'b0011) begin
            errors++;
            $display("FAIL both_fall got=%b expected=0011", {a_out, b_out, a_fall, b_fall});
        end
        idle(3);
    endtask

    task automatic test_bounce();
        int rises;
        int highs;
        rises = 0;
        highs = 0;
        for (int seg = 0; seg < 4; seg++) begin
            raw_a = (seg % 2 == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (a_rise) rises++;
                if (a_out) highs++;
            end
        end
        raw_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_rise) rises++;
            if (a_out) highs++;
        end
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL bounce_rise count=%0d expected=0", rises);
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL bounce_out high_cycles=%0d expected=0", highs);
        end
    endtask

    task automatic test_press_release();
        int rises;
        int falls;
        int both;
        rises = 0;
        falls = 0;
        both  = 0;
        raw_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_rise) rises++;
            if (a_fall) falls++;
            if (a_rise && a_fall) both++;
            if (i == 10) begin
                checks++;
                if ({a_out, a_rise} !== 2'b00) begin
                    errors++;
                    $display("FAIL press_early got=%b expected=00", {a_out, a_rise});
                end
            end
            if (i == 11) begin
                checks++;
                if ({a_out, a_rise} !== 2'b11) begin
                    errors++;
                    $display("FAIL press_rise got=%b expected=11", {a_out, a_rise});
                end
            end
        end
        raw_a = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_rise) rises++;
            if (a_fall) falls++;
            if (a_rise && a_fall) both++;
            if (i == 10) begin
                checks++;
                if ({a_out, a_fall} !== 2'b10) begin
                    errors++;
                    $display("FAIL release_early got=%b expected=10", {a_out, a_fall});
                end
            end
            if (i == 11) begin
                checks++;
                if ({a_out, a_fall} !== 2'b01) begin
                    errors++;
                    $display("FAIL release_fall got=%b expected=01", {a_out, a_fall});
                end
            end
        end
        checks++;
        if ({rises, falls, both} !== {32'd1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL press_pulse_counts rise=%0d fall=%0d both=%0d expected=1 1 0",
                     rises, falls, both);
        end
    endtask

    task automatic test_gate_drive();
        raw_a = 1'b1;
        raw_b = 1'b1;
        idle(10);
        checks++;
        if ((a_out & b_out) !== 1'b0) begin
            errors++;
            $display("FAIL gate_early and=%b expected=0", a_out & b_out);
        end
        tick();
        checks++;
        if ((a_out & b_out) !== 1'b1) begin
            errors++;
            $display("FAIL gate_and and=%b expected=1", a_out & b_out);
        end
        idle(4);
        raw_b = 1'b0;
        idle(10);
        checks++;
        if ({a_out, b_out} !== 2'b11) begin
            errors++;
            $display("FAIL gate_drop_early got=%b expected=11", {a_out, b_out});
        end
        tick();
        checks++;
        if ({a_out, b_out, b_fall, a_fall} !== 4'b1010) begin
            errors++;
            $display("FAIL gate_drop_b got=%b expected=1010", {a_out, b_out, b_fall, a_fall});
        end
        // Asynchronous reset must clear a high output between clock edges.
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== 1'b0) begin
            errors++;
            $display("FAIL async_clear a_out=%b expected=0", a_out);
        end
        raw_a = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_glitch();
        int early_rises;
        early_rises = 0;
        for (int i = 1; i <= 19; i++) begin
            raw_b = (i == 8) ? 1'b0 : 1'b1;
            tick();
            if (i <= 18 && (b_rise || b_out)) early_rises++;
        end
        checks++;
        if ({b_out, b_rise} !== 2'b11) begin
            errors++;
            $display("FAIL glitch_rise got=%b expected=11", {b_out, b_rise});
        end
        checks++;
        if (early_rises !== 0) begin
            errors++;
            $display("FAIL glitch_early cycles=%0d expected=0", early_rises);
        end
        raw_b = 1'b0;
        idle(15);
    endtask

    task automatic test_mid_reset();
        int highs;
        highs = 0;
        raw_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_out) highs++;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_out) highs++;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i <= 10 && a_out) highs++;
        end
        checks++;
        if ({a_out, a_rise} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_rise got=%b expected=11", {a_out, a_rise});
        end
        checks++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL midreset_early high_cycles=%0d expected=0", highs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        raw_a  = 1'b0;
        raw_b  = 1'b0;
        tick();
        test_reset();
        test_bounce();
        test_press_release();
        test_gate_drive();
        test_glitch();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
